mmu_stall: RTL and testbench
============================

MMU_STALL -- requirements
Module: mmu_stall

Interface
REQ-001 Parameters SHALL be: WORD_DEPTH_LOG, default 14, RAM word-address width; IO_CHANNELS, default 4, number of IO channels (1..16); IO_TIMEOUT, default 255, maximum IO wait cycles (1..65535).
REQ-002 Ports SHALL be as follows; clock is clk, reset is reset, one clock, reset synchronous and active-high:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- im_addr  in  32  instruction fetch address
- im_do  out  32  instruction data, equal to ram0_do
- ram0_addr  out  WORD_DEPTH_LOG  equal to im_addr[WORD_DEPTH_LOG+1:2]
- ram0_do  in  32  ROM/RAM port-0 read data
- dm_req  in  1  data access request
- dm_we  in  1  data write
- dm_addr  in  32  data byte address
- dm_di  in  32  store data, right-justified
- dm_be  in  4  byte enables
- is_signed  in  1  load sign-extend
- dm_do  out  32  load data, extended
- dm_valid  out  1  access-complete pulse
- dm_stall  out  1  MMU busy; requester holds inputs
- dm_fault  out  1  access fault, qualified by dm_valid
- ram1_addr  out  WORD_DEPTH_LOG  RAM port-1 word address
- ram1_di  out  32  lane-shifted store data
- ram1_we  out  1  RAM write
- ram1_be  out  4  RAM byte-lane enables
- ram1_do  in  32  RAM read data
- io_sel  out  IO_CHANNELS  one-hot channel select, registered
- io_addr  out  8  channel register offset, registered
- io_we  out  1  IO write, registered
- io_data_write  out  32  lane-shifted IO store data, registered
- io_data_read  in  32*IO_CHANNELS  per-channel read data
- io_ack  in  IO_CHANNELS  per-channel completion

Function
REQ-003 RAM region SHALL be dm_addr < 4*2^WORD_DEPTH_LOG; IO region SHALL be 0x80000000 .. 0x80000000+256*IO_CHANNELS-1, channel = dm_addr[11:8], offset = dm_addr[7:0]; all else unmapped.
REQ-004 Legal dm_be SHALL be 1111, 0011, 1100, 0001, 0010, 0100, 1000; store data SHALL shift to the enabled lanes; loads SHALL select enabled lanes, right-justify, sign-extend if is_signed else zero-extend.
REQ-005 FSM states SHALL be IDLE, IO_WAIT.
REQ-006 IDLE + dm_req to RAM: ram1_* driven combinationally that cycle, ram1_we = dm_we; dm_valid=1 next cycle with dm_do from ram1_do; dm_stall stays 0.
REQ-007 IDLE + dm_req to IO: next edge register io_sel/io_addr/io_we/io_data_write, enter IO_WAIT; dm_stall=1 combinationally from the request cycle until completion.
REQ-008 IO_WAIT: io_sel held stable; on io_ack of the selected channel, io_sel cleared, dm_valid=1 next cycle with dm_do extended from that channel's io_data_read, return to IDLE.
REQ-009 IO_WAIT: 16-bit wait counter SHALL increment each cycle; at IO_TIMEOUT without ack, io_sel cleared, dm_valid=1 and dm_fault=1 next cycle; simultaneous ack and timeout SHALL complete as ack.
REQ-010 Unmapped access or illegal dm_be SHALL produce dm_valid=1, dm_fault=1 next cycle, no RAM/IO write, no stall.
REQ-011 dm_req in IO_WAIT SHALL be ignored as new request; back-to-back RAM requests SHALL complete one per cycle.
REQ-012 io_ack on unselected channels SHALL be ignored.

Reset
REQ-013 On reset: state IDLE, counter 0, io_sel=0, io_we=0, io_addr=0, io_data_write=0, dm_valid=0, dm_fault=0, dm_do=0; reset mid-IO SHALL drop io_sel at that edge and discard the access.

Configuration
REQ-014 With MMU_MISALIGN_TRAP_EN defined: halfword at dm_addr[0]=1 or word at dm_addr[1:0]!=0 SHALL fault per REQ-010; dm_be lane checked against dm_addr[1:0].
REQ-015 Without MMU_MISALIGN_TRAP_EN: low address bits ignored for alignment, dm_be alone selects lanes, no misalign fault.

Verification
REQ-016 Word store 0xDEADBEEF to 0x00000010, then lb signed be=1000 -> ram1_be=1111 write; load dm_do=0xFFFFFFDE one cycle later, dm_stall=0.
REQ-017 Read 0x80000104, channel 1 acks after 3 cycles with 0x00001234, be=0011 unsigned -> io_sel=0010 for 3 cycles, dm_stall high, dm_valid with dm_do=0x00001234.
REQ-018 IO read channel 2 with no ack, IO_TIMEOUT=8 -> io_sel cleared after 8 wait cycles, dm_valid=1, dm_fault=1.
REQ-019 Access 0x40000000 -> dm_valid=1, dm_fault=1 next cycle, ram1_we=0, io_sel=0.
REQ-020 Reset asserted during IO_WAIT -> io_sel=0 at next edge, no dm_valid, next RAM request completes normally.
REQ-021 Word load at 0x00000002 -> dm_fault=1 with MMU_MISALIGN_TRAP_EN; without it, normal completion.

Source files
------------

// File: rtl/mmu_stall.sv
// mmu_stall: data-side memory management unit with IO stall handling.
//
// Decodes each data access into RAM, IO or unmapped space. RAM accesses go
// straight to RAM port 1 and complete the following cycle without stalling.
// IO accesses register a one-hot channel select and stall the requester
// until the selected channel acknowledges or the wait counter times out.
// Unmapped addresses and illegal byte enables fault the following cycle.
// Instruction fetch is a pass-through to RAM port 0.
//
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   im_addr / im_do      instruction fetch address / data
//   ram0_addr / ram0_do  RAM port 0 (fetch)
//   dm_*                 data requester side (req, we, addr, di, be,
//                        is_signed in; do, valid, stall, fault out)
//   ram1_*               RAM port 1 (data)
//   io_*                 IO channel bus (registered select/addr/we/data,
//                        per-channel read data and ack)
//
// Build option: MMU_MISALIGN_TRAP_EN -- when defined, the byte enables must
// match dm_addr[1:0] (word at 0, halfword at 0 or 2, byte at its own lane),
// otherwise the access faults. When undefined, dm_be alone selects lanes.

module mmu_stall #(
  parameter int WORD_DEPTH_LOG = 14,
  parameter int IO_CHANNELS    = 4,
  parameter int IO_TIMEOUT     = 255
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [31:0]                 im_addr,
  output logic [31:0]                 im_do,
  output logic [WORD_DEPTH_LOG-1:0]   ram0_addr,
  input  logic [31:0]                 ram0_do,
  input  logic                        dm_req,
  input  logic                        dm_we,
  input  logic [31:0]                 dm_addr,
  input  logic [31:0]                 dm_di,
  input  logic [3:0]                  dm_be,
  input  logic                        is_signed,
  output logic [31:0]                 dm_do,
  output logic                        dm_valid,
  output logic                        dm_stall,
  output logic                        dm_fault,
  output logic [WORD_DEPTH_LOG-1:0]   ram1_addr,
  output logic [31:0]                 ram1_di,
  output logic                        ram1_we,
  output logic [3:0]                  ram1_be,
  input  logic [31:0]                 ram1_do,
  output logic [IO_CHANNELS-1:0]      io_sel,
  output logic [7:0]                  io_addr,
  output logic                        io_we,
  output logic [31:0]                 io_data_write,
  input  logic [32*IO_CHANNELS-1:0]   io_data_read,
  input  logic [IO_CHANNELS-1:0]      io_ack
);

  // state    | meaning
  // S_IDLE   | accepting requests; RAM and faulting accesses complete next cycle
  // S_IO_WAIT| IO channel selected, waiting for its ack or the timeout
  localparam logic [0:0] S_IDLE    = 1'b0;
  localparam logic [0:0] S_IO_WAIT = 1'b1;

  localparam logic [15:0] TMO_LAST = 16'(IO_TIMEOUT - 1);

  function automatic logic [31:0] lane_store(input logic [31:0] d, input logic [3:0] be);
    case (be)
      4'b0011: lane_store = {16'h0, d[15:0]};
      4'b1100: lane_store = {d[15:0], 16'h0};
      4'b0001: lane_store = {24'h0, d[7:0]};
      4'b0010: lane_store = {16'h0, d[7:0], 8'h0};
      4'b0100: lane_store = {8'h0, d[7:0], 16'h0};
      4'b1000: lane_store = {d[7:0], 24'h0};
      default: lane_store = d;
    endcase
  endfunction

  function automatic logic [31:0] lane_load(input logic [31:0] w, input logic [3:0] be,
                                            input logic sgn);
    case (be)
      4'b0011: lane_load = {{16{sgn & w[15]}}, w[15:0]};
      4'b1100: lane_load = {{16{sgn & w[31]}}, w[31:16]};
      4'b0001: lane_load = {{24{sgn & w[7]}},  w[7:0]};
      4'b0010: lane_load = {{24{sgn & w[15]}}, w[15:8]};
      4'b0100: lane_load = {{24{sgn & w[23]}}, w[23:16]};
      4'b1000: lane_load = {{24{sgn & w[31]}}, w[31:24]};
      default: lane_load = w;
    endcase
  endfunction

  logic [0:0]             state_q, state_d;
  logic [15:0]            cnt_q, cnt_d;
  logic [IO_CHANNELS-1:0] io_sel_q, io_sel_d;
  logic [7:0]             io_addr_q, io_addr_d;
  logic                   io_we_q, io_we_d;
  logic [31:0]            io_wdata_q, io_wdata_d;
  logic                   dm_valid_q, dm_fault_q, rsp_ram_q, sgn_q;
  logic [31:0]            dm_do_q;
  logic [3:0]             be_q;

  logic ram_hit, io_hit, be_ok, align_ok, acc_ok;
  logic idle, ram_go, io_go, bad_go, ack_hit, tmo_hit;
  logic [31:0] io_rdata;

  assign im_do     = ram0_do;
  assign ram0_addr = im_addr[WORD_DEPTH_LOG+1:2];

  logic unused_im;
  assign unused_im = ^{im_addr[31:WORD_DEPTH_LOG+2], im_addr[1:0]};

  assign ram_hit = (dm_addr[31:WORD_DEPTH_LOG+2] == '0);
  assign io_hit  = dm_addr[31] && (dm_addr[30:12] == '0) &&
                   ({1'b0, dm_addr[11:8]} < 5'(IO_CHANNELS));

  always_comb begin
    case (dm_be)
      4'b1111, 4'b0011, 4'b1100,
      4'b0001, 4'b0010, 4'b0100, 4'b1000: be_ok = 1'b1;
      default:                            be_ok = 1'b0;
    endcase
  end

`ifdef MMU_MISALIGN_TRAP_EN
  always_comb begin
    case (dm_be)
      4'b1111, 4'b0011, 4'b0001: align_ok = (dm_addr[1:0] == 2'd0);
      4'b1100, 4'b0100:          align_ok = (dm_addr[1:0] == 2'd2);
      4'b0010:                   align_ok = (dm_addr[1:0] == 2'd1);
      4'b1000:                   align_ok = (dm_addr[1:0] == 2'd3);
      default:                   align_ok = 1'b0;
    endcase
  end
`else
  assign align_ok = 1'b1;
`endif

  assign acc_ok  = be_ok && align_ok;
  assign idle    = (state_q == S_IDLE);
  assign ram_go  = idle && dm_req && ram_hit && acc_ok;
  assign io_go   = idle && dm_req && io_hit && acc_ok;
  assign bad_go  = idle && dm_req && !((ram_hit || io_hit) && acc_ok);
  assign ack_hit = !idle && |(io_ack & io_sel_q);
  // An ack in the same cycle as the timeout wins.
  assign tmo_hit = !idle && !ack_hit && (cnt_q == TMO_LAST);

  // Stall drops in the cycle the IO access resolves, so the requester moves
  // on at that edge and the held request is not re-accepted in IDLE.
  assign dm_stall = io_go || (!idle && !ack_hit && !tmo_hit);

  assign ram1_addr = dm_addr[WORD_DEPTH_LOG+1:2];
  assign ram1_di   = lane_store(dm_di, dm_be);
  assign ram1_we   = ram_go && dm_we;
  assign ram1_be   = ram_go ? dm_be : 4'b0000;

  always_comb begin
    io_rdata = '0;
    for (int c = 0; c < IO_CHANNELS; c++) begin
      if (io_sel_q[c]) io_rdata = io_rdata | io_data_read[c*32 +: 32];
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    io_sel_d   = io_sel_q;
    io_addr_d  = io_addr_q;
    io_we_d    = io_we_q;
    io_wdata_d = io_wdata_q;
    if (idle) begin
      if (io_go) begin
        state_d    = S_IO_WAIT;
        cnt_d      = '0;
        io_sel_d   = IO_CHANNELS'(1) << dm_addr[11:8];
        io_addr_d  = dm_addr[7:0];
        io_we_d    = dm_we;
        io_wdata_d = lane_store(dm_di, dm_be);
      end
    end else if (ack_hit || tmo_hit) begin
      state_d  = S_IDLE;
      io_sel_d = '0;
      io_we_d  = 1'b0;
    end else begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      io_sel_q   <= '0;
      io_addr_q  <= '0;
      io_we_q    <= 1'b0;
      io_wdata_q <= '0;
      dm_valid_q <= 1'b0;
      dm_fault_q <= 1'b0;
      dm_do_q    <= '0;
      rsp_ram_q  <= 1'b0;
      be_q       <= '0;
      sgn_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      io_sel_q   <= io_sel_d;
      io_addr_q  <= io_addr_d;
      io_we_q    <= io_we_d;
      io_wdata_q <= io_wdata_d;
      dm_valid_q <= ram_go || bad_go || ack_hit || tmo_hit;
      dm_fault_q <= bad_go || tmo_hit;
      rsp_ram_q  <= ram_go;
      if (idle && dm_req) begin
        be_q  <= dm_be;
        sgn_q <= is_signed;
      end
      if (ack_hit)              dm_do_q <= lane_load(io_rdata, be_q, sgn_q);
      else if (bad_go || tmo_hit) dm_do_q <= '0;
    end
  end

  // RAM read data arrives the cycle after the address, so it is extended
  // combinationally in the response cycle.
  assign dm_do         = rsp_ram_q ? lane_load(ram1_do, be_q, sgn_q) : dm_do_q;
  assign dm_valid      = dm_valid_q;
  assign dm_fault      = dm_fault_q;
  assign io_sel        = io_sel_q;
  assign io_addr       = io_addr_q;
  assign io_we         = io_we_q;
  assign io_data_write = io_wdata_q;

endmodule

// File: tb/tb_mmu_stall.sv
module tb_mmu_stall;
  localparam int W   = 14;
  localparam int NCH = 4;
  localparam int TMO = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset;
  logic [31:0]     im_addr, im_do, ram0_do;
  logic [W-1:0]    ram0_addr, ram1_addr;
  logic            dm_req, dm_we, is_signed;
  logic [31:0]     dm_addr, dm_di, dm_do;
  logic [3:0]      dm_be, ram1_be;
  logic            dm_valid, dm_stall, dm_fault;
  logic [31:0]     ram1_di, ram1_do;
  logic            ram1_we;
  logic [NCH-1:0]  io_sel, io_ack;
  logic [7:0]      io_addr;
  logic            io_we;
  logic [31:0]     io_data_write;
  logic [32*NCH-1:0] io_data_read;

  mmu_stall #(.WORD_DEPTH_LOG(W), .IO_CHANNELS(NCH), .IO_TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .im_addr(im_addr), .im_do(im_do), .ram0_addr(ram0_addr), .ram0_do(ram0_do),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_di(dm_di), .dm_be(dm_be),
    .is_signed(is_signed), .dm_do(dm_do), .dm_valid(dm_valid), .dm_stall(dm_stall),
    .dm_fault(dm_fault), .ram1_addr(ram1_addr), .ram1_di(ram1_di), .ram1_we(ram1_we),
    .ram1_be(ram1_be), .ram1_do(ram1_do), .io_sel(io_sel), .io_addr(io_addr),
    .io_we(io_we), .io_data_write(io_data_write), .io_data_read(io_data_read),
    .io_ack(io_ack)
  );

  // Synchronous RAM model: one-cycle read latency, byte-lane writes.
  logic [31:0] mem [0:(1<<W)-1] = '{default: 32'h0};
  assign ram0_do = mem[ram0_addr];
  always @(posedge clk) begin
    if (ram1_we)
      for (int i = 0; i < 4; i++)
        if (ram1_be[i]) mem[ram1_addr][8*i +: 8] <= ram1_di[8*i +: 8];
    ram1_do <= mem[ram1_addr];
  end

  typedef struct packed {
    logic [31:0] d;
    logic        f;
    logic        cd;   // compare dm_do
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_rsp(input logic [31:0] d, input logic f, input logic cd);
    exp_t e;
    e.d = d; e.f = f; e.cd = cd;
    exp_q.push_back(e);
  endtask

  task automatic issue(input logic we, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] be, input logic sgn);
    dm_req = 1'b1; dm_we = we; dm_addr = a; dm_di = d; dm_be = be; is_signed = sgn;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  // Response monitor: every dm_valid pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (!reset && dm_valid) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL unexpected_valid actual do=%h fault=%b required no response at %0t",
                 dm_do, dm_fault, $time);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e.cd) check("rsp_do", dm_do, mon_e.d);
        check("rsp_fault", 32'(dm_fault), 32'(mon_e.f));
      end
    end
  end

  initial begin
    reset = 1'b1; im_addr = '0; dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_di = '0;
    dm_be = '0; is_signed = 1'b0; io_data_read = '0; io_ack = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    mid();
    check("rst_valid", 32'(dm_valid), 32'd0);
    check("rst_fault", 32'(dm_fault), 32'd0);
    check("rst_do", dm_do, 32'd0);
    check("rst_io_sel", 32'(io_sel), 32'd0);
    check("rst_io_we", 32'(io_we), 32'd0);
    check("rst_io_addr", 32'(io_addr), 32'd0);
    check("rst_io_wdata", io_data_write, 32'd0);
    check("rst_stall", 32'(dm_stall), 32'd0);
    tick();

    // Back-to-back RAM traffic, one access per cycle.
    issue(1'b1, 32'h10, 32'hDEADBEEF, 4'b1111, 1'b0); expect_rsp(32'h0, 1'b0, 1'b0);
    mid();
    check("sw_we", 32'(ram1_we), 32'd1);
    check("sw_be", 32'(ram1_be), 32'hF);
    check("sw_di", ram1_di, 32'hDEADBEEF);
    check("sw_addr", 32'(ram1_addr), 32'd4);
    check("sw_stall", 32'(dm_stall), 32'd0);
    tick();
    issue(1'b0, 32'h13, 32'h0, 4'b1000, 1'b1); expect_rsp(32'hFFFFFFDE, 1'b0, 1'b1);
    mid();
    check("lb_we", 32'(ram1_we), 32'd0);
    check("lb_be", 32'(ram1_be), 32'h8);
    tick();
    mid(); check("lb_stall", 32'(dm_stall), 32'd0);
    issue(1'b0, 32'h10, 32'h0, 4'b0011, 1'b0); expect_rsp(32'h0000BEEF, 1'b0, 1'b1);
    tick();
    issue(1'b1, 32'h12, 32'h00005A5A, 4'b1100, 1'b0); expect_rsp(32'h0, 1'b0, 1'b0);
    mid();
    check("sh_di", ram1_di, 32'h5A5A0000);
    check("sh_be", 32'(ram1_be), 32'hC);
    tick();
    issue(1'b0, 32'h10, 32'h0, 4'b1111, 1'b0); expect_rsp(32'h5A5ABEEF, 1'b0, 1'b1);
    tick();
    issue(1'b0, 32'h11, 32'h0, 4'b0010, 1'b0); expect_rsp(32'h000000BE, 1'b0, 1'b1);
    tick();
    issue(1'b0, 32'h12, 32'h0, 4'b1100, 1'b1); expect_rsp(32'h00005A5A, 1'b0, 1'b1);
    tick();
    issue(1'b0, 32'h10, 32'h0, 4'b0011, 1'b1); expect_rsp(32'hFFFFBEEF, 1'b0, 1'b1);
    tick();
    issue(1'b1, 32'h0, 32'h11223344, 4'b1111, 1'b0); expect_rsp(32'h0, 1'b0, 1'b0);
    tick();
    dm_req = 1'b0;
    tick();

    // IO read on channel 1, acked in the third wait cycle; a stray ack on
    // channel 0 during the wait must be ignored.
    issue(1'b0, 32'h80000104, 32'h0, 4'b0011, 1'b0); expect_rsp(32'h00001234, 1'b0, 1'b1);
    mid();
    check("ior_stall0", 32'(dm_stall), 32'd1);
    check("ior_sel0", 32'(io_sel), 32'd0);
    tick();
    io_ack = 4'b0001; io_data_read[31:0] = 32'hFFFFFFFF;
    mid();
    check("ior_sel1", 32'(io_sel), 32'b0010);
    check("ior_addr", 32'(io_addr), 32'h04);
    check("ior_we", 32'(io_we), 32'd0);
    check("ior_stall1", 32'(dm_stall), 32'd1);
    tick();
    io_ack = 4'b0000;
    mid();
    check("ior_sel2", 32'(io_sel), 32'b0010);
    check("ior_stall2", 32'(dm_stall), 32'd1);
    tick();
    io_ack = 4'b0010; io_data_read[63:32] = 32'hABCD1234;
    mid(); check("ior_sel3", 32'(io_sel), 32'b0010);
    tick();
    io_ack = 4'b0000; dm_req = 1'b0;
    mid();
    check("ior_sel_clr", 32'(io_sel), 32'd0);
    check("ior_stall_done", 32'(dm_stall), 32'd0);
    tick();

    // IO byte write on channel 3, acked immediately.
    issue(1'b1, 32'h8000030A, 32'h00000077, 4'b0100, 1'b0); expect_rsp(32'h0, 1'b0, 1'b1);
    mid(); check("iow_stall0", 32'(dm_stall), 32'd1);
    tick();
    io_ack = 4'b1000;
    mid();
    check("iow_sel", 32'(io_sel), 32'b1000);
    check("iow_we", 32'(io_we), 32'd1);
    check("iow_addr", 32'(io_addr), 32'h0A);
    check("iow_data", io_data_write, 32'h00770000);
    tick();
    io_ack = 4'b0000; dm_req = 1'b0;
    mid();
    check("iow_sel_clr", 32'(io_sel), 32'd0);
    check("iow_we_clr", 32'(io_we), 32'd0);
    tick();

    // IO read on channel 2 that never acks: select held TMO cycles, then fault.
    issue(1'b0, 32'h80000200, 32'h0, 4'b1111, 1'b0); expect_rsp(32'h0, 1'b1, 1'b0);
    mid(); check("tmo_stall0", 32'(dm_stall), 32'd1);
    tick();
    for (int k = 1; k <= TMO; k++) begin
      mid(); check("tmo_sel_held", 32'(io_sel), 32'b0100);
      tick();
    end
    dm_req = 1'b0;
    mid(); check("tmo_sel_clr", 32'(io_sel), 32'd0);
    tick();

    // Unmapped, illegal byte enable, and out-of-range IO channel all fault.
    issue(1'b1, 32'h40000000, 32'h1, 4'b1111, 1'b0); expect_rsp(32'h0, 1'b1, 1'b0);
    mid();
    check("unm_we", 32'(ram1_we), 32'd0);
    check("unm_stall", 32'(dm_stall), 32'd0);
    tick();
    issue(1'b1, 32'h20, 32'h1, 4'b0101, 1'b0); expect_rsp(32'h0, 1'b1, 1'b0);
    mid();
    check("unm_sel", 32'(io_sel), 32'd0);
    check("badbe_we", 32'(ram1_we), 32'd0);
    tick();
    issue(1'b0, 32'h80000400, 32'h0, 4'b1111, 1'b0); expect_rsp(32'h0, 1'b1, 1'b0);
    mid(); check("badch_stall", 32'(dm_stall), 32'd0);
    tick();
    dm_req = 1'b0;
    mid(); check("badch_sel", 32'(io_sel), 32'd0);
    tick();

    // Reset during IO_WAIT discards the access.
    issue(1'b0, 32'h80000000, 32'h0, 4'b1111, 1'b0);
    tick();
    mid(); check("rstio_sel", 32'(io_sel), 32'b0001);
    reset = 1'b1; dm_req = 1'b0;
    tick();
    reset = 1'b0;
    mid();
    check("rstio_sel_clr", 32'(io_sel), 32'd0);
    check("rstio_stall", 32'(dm_stall), 32'd0);
    tick();
    issue(1'b0, 32'h10, 32'h0, 4'b1111, 1'b0); expect_rsp(32'h5A5ABEEF, 1'b0, 1'b1);
    tick();
    dm_req = 1'b0;
    tick();

    // Word load at a non-word-aligned address.
    issue(1'b0, 32'h2, 32'h0, 4'b1111, 1'b0);
`ifdef MMU_MISALIGN_TRAP_EN
    expect_rsp(32'h0, 1'b1, 1'b0);
`else
    expect_rsp(32'h11223344, 1'b0, 1'b1);
`endif
    tick();
    dm_req = 1'b0;
    repeat (3) tick();

    check("pending_rsp", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
